// File: rtl/p_rf_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// p_rf_wb_arbiter_if
// Bundles all signals of the writeback arbiter except clk and rst_n.
//   Writeback requests : req0_*/req1_* (valid, rd, data in; ready out)
//   Stall              : wb_stall
//   Register-file port : wr_enable, rd_address, wr_data
//   Issue / scoreboard : issue_valid, issue_rd, issue_ready, busy[31:0]
//   Hazard query       : rs1_address, rs2_address, rs3_address, hazard
//   Optional forwarding: fwd_hit[2:0], present only with P_WB_BYPASS_EN
// Modports: slave = arbiter side, master = pipeline / environment side.
// -----------------------------------------------------------------------------
interface p_rf_wb_arbiter_if #(
    parameter int REG_WIDTH = 64
);
    logic                 req0_valid;
    logic [4:0]           req0_rd;
    logic [REG_WIDTH-1:0] req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [4:0]           req1_rd;
    logic [REG_WIDTH-1:0] req1_data;
    logic                 req1_ready;
    logic                 wb_stall;
    logic                 wr_enable;
    logic [4:0]           rd_address;
    logic [REG_WIDTH-1:0] wr_data;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic                 issue_ready;
    logic [4:0]           rs1_address;
    logic [4:0]           rs2_address;
    logic [4:0]           rs3_address;
    logic                 hazard;
    logic [31:0]          busy;
`ifdef P_WB_BYPASS_EN
    logic [2:0]           fwd_hit;
`endif

    modport slave (
`ifdef P_WB_BYPASS_EN
        output fwd_hit,
`endif
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        input  wb_stall,
        output wr_enable, rd_address, wr_data,
        input  issue_valid, issue_rd,
        output issue_ready,
        input  rs1_address, rs2_address, rs3_address,
        output hazard, busy
    );

    modport master (
`ifdef P_WB_BYPASS_EN
        input  fwd_hit,
`endif
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        output wb_stall,
        input  wr_enable, rd_address, wr_data,
        output issue_valid, issue_rd,
        input  issue_ready,
        output rs1_address, rs2_address, rs3_address,
        input  hazard, busy
    );
endinterface

// File: rtl/p_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// p_rf_wb_arbiter
// Two-pipe writeback arbiter with a 32-entry in-flight scoreboard.
//   - Round-robin grant between pipe 0 and pipe 1 (combinational ready).
//   - Winning request is registered onto the register-file write port
//     (wr_enable / rd_address / wr_data) one cycle later.
//   - busy[n] is set by an accepted issue of rd n and cleared the edge after
//     the write of rd n leaves the write port; a simultaneous set wins.
//   - hazard flags any source operand whose register is still in flight.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active HIGH despite its name
//   wb    : p_rf_wb_arbiter_if.slave bundle (requests, write port, scoreboard)
// Build option:
//   P_WB_BYPASS_EN : operands matching the write currently on the write port
//                    are not reported as hazards; fwd_hit[2:0] reports
//                    which of rs1/rs2/rs3 (bit 0/1/2) matched.
// -----------------------------------------------------------------------------
module p_rf_wb_arbiter #(
    parameter int REG_WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    p_rf_wb_arbiter_if.slave wb
);
    logic                 grant0_s;
    logic                 grant1_s;
    logic                 xfer0_s;
    logic                 xfer1_s;
    // 1 = pipe 1 won last, so pipe 0 wins the next contention
    logic                 last_grant_r;
    logic                 wr_enable_r;
    logic [4:0]           rd_address_r;
    logic [REG_WIDTH-1:0] wr_data_r;
    logic [31:0]          busy_r;
    logic [31:0]          busy_nxt_s;
    logic [31:0]          clr_mask_s;
    logic [31:0]          set_mask_s;
    logic                 issue_ready_s;
    logic                 hazard_s;
`ifdef P_WB_BYPASS_EN
    logic [2:0]           match_s;
`endif

    // Round-robin grant; nothing is granted under stall or reset
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n || wb.wb_stall) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            case ({wb.req0_valid, wb.req1_valid})
                2'b10: grant0_s = 1'b1;
                2'b01: grant1_s = 1'b1;
                2'b11: begin
                    grant0_s = last_grant_r;
                    grant1_s = ~last_grant_r;
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end
    end

    assign xfer0_s = wb.req0_valid & grant0_s;
    assign xfer1_s = wb.req1_valid & grant1_s;

    // Last-grant pointer moves only on a completed transfer
    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_grant_r <= 1'b1;
        end else if (xfer0_s) begin
            last_grant_r <= 1'b0;
        end else if (xfer1_s) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Register-file write port; address/data hold when idle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_enable_r  <= 1'b0;
            rd_address_r <= 5'd0;
            wr_data_r    <= {REG_WIDTH{1'b0}};
        end else if (xfer0_s) begin
            wr_enable_r  <= 1'b1;
            rd_address_r <= wb.req0_rd;
            wr_data_r    <= wb.req0_data;
        end else if (xfer1_s) begin
            wr_enable_r  <= 1'b1;
            rd_address_r <= wb.req1_rd;
            wr_data_r    <= wb.req1_data;
        end else begin
            wr_enable_r  <= 1'b0;
        end
    end

    assign issue_ready_s = ~busy_r[wb.issue_rd];

    // Scoreboard next state; OR-ing the set mask last lets issue beat clear
    always_comb begin
        clr_mask_s = 32'd0;
        set_mask_s = 32'd0;
        if (wr_enable_r) begin
            clr_mask_s = 32'd1 << rd_address_r;
        end else begin
            clr_mask_s = 32'd0;
        end
        if (wb.issue_valid && issue_ready_s) begin
            set_mask_s = 32'd1 << wb.issue_rd;
        end else begin
            set_mask_s = 32'd0;
        end
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

`ifdef P_WB_BYPASS_EN
    // Operands matching the write on the port can take it by forwarding
    always_comb begin
        match_s[0] = wr_enable_r && (wb.rs1_address == rd_address_r);
        match_s[1] = wr_enable_r && (wb.rs2_address == rd_address_r);
        match_s[2] = wr_enable_r && (wb.rs3_address == rd_address_r);
        hazard_s   = (busy_r[wb.rs1_address] & ~match_s[0]) |
                     (busy_r[wb.rs2_address] & ~match_s[1]) |
                     (busy_r[wb.rs3_address] & ~match_s[2]);
    end

    assign wb.fwd_hit = match_s;
`else
    // Any in-flight source operand is a hazard
    always_comb begin
        hazard_s = busy_r[wb.rs1_address] |
                   busy_r[wb.rs2_address] |
                   busy_r[wb.rs3_address];
    end
`endif

    assign wb.req0_ready  = grant0_s;
    assign wb.req1_ready  = grant1_s;
    assign wb.wr_enable   = wr_enable_r;
    assign wb.rd_address  = rd_address_r;
    assign wb.wr_data     = wr_data_r;
    assign wb.issue_ready = issue_ready_s;
    assign wb.hazard      = hazard_s;
    assign wb.busy        = busy_r;
endmodule

// File: tb/tb_p_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_p_rf_wb_arbiter
// Table-driven bench for p_rf_wb_arbiter. Each row gives one cycle of inputs,
// the expected combinational outputs for that cycle and the expected
// scoreboard after the edge. The expected write-port contents are pushed to a
// queue when the row is driven and popped after the edge. Expected hazard
// values that depend on P_WB_BYPASS_EN use the BYP constant.
// -----------------------------------------------------------------------------
module tb_p_rf_wb_arbiter;
    localparam logic [63:0] D0 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] D1 = 64'h5A5A_5A5A_5A5A_5A5A;
`ifdef P_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst, stall, v0, v1;
        logic [4:0]  rd0, rd1;
        logic        iv;
        logic [4:0]  ird, rs1, rs2, rs3;
        logic        e_r0, e_r1, e_ir, e_hz;
        logic [2:0]  e_fwd;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   row;
    logic [4:0]  held_rd;
    logic [63:0] held_data;
    vec_t vecs[$];
    wr_t  sb[$];

    p_rf_wb_arbiter_if #(.REG_WIDTH(64)) wb_if ();

    p_rf_wb_arbiter #(.REG_WIDTH(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic stall, input logic v0, input logic v1,
                       input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                       input logic e_r0, input logic e_r1, input logic e_ir, input logic e_hz,
                       input logic [2:0] e_fwd, input logic [31:0] e_busy);
        vec_t v;
        v.rst = rst; v.stall = stall; v.v0 = v0; v.v1 = v1;
        v.rd0 = rd0; v.rd1 = rd1; v.iv = iv; v.ird = ird;
        v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ir = e_ir; v.e_hz = e_hz;
        v.e_fwd = e_fwd; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        wr_t e;
        @(negedge clk);
        rst_n                = v.rst;
        wb_if.wb_stall       = v.stall;
        wb_if.req0_valid     = v.v0;
        wb_if.req1_valid     = v.v1;
        wb_if.req0_rd        = v.rd0;
        wb_if.req1_rd        = v.rd1;
        wb_if.req0_data      = D0;
        wb_if.req1_data      = D1;
        wb_if.issue_valid    = v.iv;
        wb_if.issue_rd       = v.ird;
        wb_if.rs1_address    = v.rs1;
        wb_if.rs2_address    = v.rs2;
        wb_if.rs3_address    = v.rs3;
        #1;
        chk("req0_ready", {63'd0, wb_if.req0_ready}, {63'd0, v.e_r0});
        chk("req1_ready", {63'd0, wb_if.req1_ready}, {63'd0, v.e_r1});
        chk("issue_ready", {63'd0, wb_if.issue_ready}, {63'd0, v.e_ir});
        chk("hazard", {63'd0, wb_if.hazard}, {63'd0, v.e_hz});
`ifdef P_WB_BYPASS_EN
        chk("fwd_hit", {61'd0, wb_if.fwd_hit}, {61'd0, v.e_fwd});
`endif
        // Expected write-port contents after this edge
        if (v.rst) begin
            e = '{1'b0, 5'd0, 64'd0};
        end else if (v.v0 && v.e_r0) begin
            e = '{1'b1, v.rd0, D0};
        end else if (v.v1 && v.e_r1) begin
            e = '{1'b1, v.rd1, D1};
        end else begin
            e = '{1'b0, held_rd, held_data};
        end
        held_rd   = e.rd;
        held_data = e.data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wr_enable", {63'd0, wb_if.wr_enable}, {63'd0, e.we});
        chk("rd_address", {59'd0, wb_if.rd_address}, {59'd0, e.rd});
        chk("wr_data", wb_if.wr_data, e.data);
        chk("busy", {32'd0, wb_if.busy}, {32'd0, v.e_busy});
    endtask

    initial begin
        vec_t h;
        total = 0;
        bad   = 0;
        row   = -1;
        held_rd   = 5'd0;
        held_data = 64'd0;
        rst_n = 1'b1;
        wb_if.wb_stall    = 1'b0;
        wb_if.req0_valid  = 1'b0;
        wb_if.req1_valid  = 1'b0;
        wb_if.req0_rd     = 5'd0;
        wb_if.req1_rd     = 5'd0;
        wb_if.req0_data   = 64'd0;
        wb_if.req1_data   = 64'd0;
        wb_if.issue_valid = 1'b0;
        wb_if.issue_rd    = 5'd0;
        wb_if.rs1_address = 5'd0;
        wb_if.rs2_address = 5'd0;
        wb_if.rs3_address = 5'd0;
        @(posedge clk);
        #1;

        //  rst st v0 v1 rd0 rd1 iv ird rs1 rs2 rs3 r0 r1 ir hz fwd busy
        // reset with both requests pending
        add(1, 0, 1, 1,  3,  4, 0, 0,  0, 0, 0,  0, 0, 1, 0,      3'b000, 32'h0);
        add(1, 0, 1, 1,  3,  4, 0, 0,  0, 0, 0,  0, 0, 1, 0,      3'b000, 32'h0);
        // contention alternates 0,1,0,1 starting with pipe 0
        add(0, 0, 1, 1,  3,  4, 0, 0,  0, 0, 0,  1, 0, 1, 0,      3'b000, 32'h0);
        add(0, 0, 1, 1,  3,  4, 0, 0,  0, 0, 0,  0, 1, 1, 0,      3'b000, 32'h0);
        add(0, 0, 1, 1,  3,  4, 0, 0,  0, 0, 0,  1, 0, 1, 0,      3'b000, 32'h0);
        add(0, 0, 1, 1,  3,  4, 0, 0,  0, 0, 0,  0, 1, 1, 0,      3'b000, 32'h0);
        // issue rd5, read it, write it back from pipe 1
        add(0, 0, 0, 0,  3,  4, 1, 5,  0, 5, 0,  0, 0, 1, 0,      3'b000, 32'h20);
        add(0, 0, 0, 1,  3,  5, 0, 0,  0, 5, 0,  0, 1, 1, 1,      3'b000, 32'h20);
        add(0, 0, 0, 0,  3,  5, 0, 0,  0, 5, 0,  0, 0, 1, !BYP,   3'b010, 32'h0);
        add(0, 0, 0, 0,  3,  5, 1, 7,  0, 5, 0,  0, 0, 1, 0,      3'b000, 32'h80);
        // WAW block on 7, then issue 9 in the same cycle its write clears
        add(0, 0, 1, 0,  9,  5, 1, 7,  7, 0, 0,  1, 0, 0, 1,      3'b000, 32'h80);
        add(0, 0, 0, 0,  9,  5, 1, 9,  9, 0, 0,  0, 0, 1, 0,      3'b001, 32'h280);
        add(0, 0, 0, 1,  9,  7, 0, 0,  9, 0, 0,  0, 1, 1, 1,      3'b000, 32'h280);
        add(0, 0, 0, 0,  9,  7, 0, 0,  7, 0, 0,  0, 0, 1, !BYP,   3'b001, 32'h200);
        add(0, 0, 0, 0,  9,  7, 0, 0,  7, 9, 0,  0, 0, 1, 1,      3'b000, 32'h200);
        // stall for 3 cycles, register 0 issued and written
        add(0, 1, 1, 0,  0,  7, 1, 0,  0, 0, 0,  0, 0, 1, 0,      3'b000, 32'h201);
        add(0, 1, 1, 0,  0,  7, 0, 0,  0, 0, 0,  0, 0, 0, 1,      3'b000, 32'h201);
        add(0, 1, 1, 0,  0,  7, 0, 0,  0, 0, 0,  0, 0, 0, 1,      3'b000, 32'h201);
        add(0, 0, 1, 0,  0,  7, 0, 0,  0, 0, 0,  1, 0, 0, 1,      3'b000, 32'h201);
        add(0, 0, 0, 0,  0,  7, 0, 0,  0, 0, 0,  0, 0, 0, !BYP,   3'b111, 32'h200);
        // contention after a pipe-0 win, then reset over an in-flight write
        add(0, 0, 1, 1, 11, 12, 0, 0,  0, 0, 0,  0, 1, 1, 0,      3'b000, 32'h200);
        add(0, 0, 1, 1, 11, 12, 0, 0,  0, 0, 0,  1, 0, 1, 0,      3'b000, 32'h200);
        add(1, 0, 1, 1, 11, 12, 0, 0,  0, 0, 0,  0, 0, 1, 0,      3'b000, 32'h0);
        add(0, 0, 1, 1, 11, 12, 0, 0,  0, 0, 0,  1, 0, 1, 0,      3'b000, 32'h0);
        add(0, 0, 0, 0, 11, 12, 0, 0,  0, 0, 0,  0, 0, 1, 0,      3'b000, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            run_vec(vecs[i]);
        end

        // Stall under contention must not move the pointer (pipe 0 won last)
        row = 100;
        h = vecs[23];
        h.stall = 1'b1;
        h.e_r0  = 1'b0;
        h.e_r1  = 1'b0;
        run_vec(h);
        row = 101;
        h.stall = 1'b0;
        h.e_r1  = 1'b1;
        run_vec(h);
        row = 102;
        h.e_r0  = 1'b1;
        h.e_r1  = 1'b0;
        run_vec(h);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/p_rf_wb_arbiter.md
P_RF_WB_ARBITER -- requirements
Module: p_rf_wb_arbiter

Interface
REQ-001 The block SHALL have one parameter: REG_WIDTH, default 64, width of one packed-SIMD register word.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset, synchronous and active-high (asserted = 1).
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 bit each, writeback requests from execution pipe 0/1.
REQ-005 The block SHALL have ports req0_rd/req1_rd, input, 5 bits each, destination register of each request.
REQ-006 The block SHALL have ports req0_data/req1_data, input, REG_WIDTH bits each, result data of each request.
REQ-007 The block SHALL have ports req0_ready/req1_ready, output, 1 bit each, grant; a transfer occurs when valid and ready are both 1.
REQ-008 The block SHALL have port wb_stall, input, 1 bit; when 1, no grant is issued.
REQ-009 The block SHALL have ports wr_enable (1 bit), rd_address (5 bits), wr_data (REG_WIDTH bits), outputs, driving the register-file write port.
REQ-010 The block SHALL have ports issue_valid (1 bit) and issue_rd (5 bits), inputs, marking a destination as in flight; issue_ready, output, 1 bit, accepts it.
REQ-011 The block SHALL have ports rs1_address/rs2_address/rs3_address, input, 5 bits each, and hazard, output, 1 bit.
REQ-012 The block SHALL have port busy, output, 32 bits, scoreboard contents (bit n = register n in flight).

Function
REQ-013 Arbitration SHALL be combinational: a requester with only its own valid high is granted; with both high, the one not granted last is granted.
REQ-014 The last-grant pointer SHALL update only on a completed transfer; its reset value SHALL select pipe 0 first (pointer = 1).
REQ-015 ready SHALL be 0 for both requesters while wb_stall = 1 or rst_n = 1; at most one ready SHALL be 1 in any cycle.
REQ-016 A transfer SHALL register wr_enable = 1, rd_address = req_rd and wr_data = req_data for exactly the next cycle (latency 1); with no transfer, wr_enable SHALL be 0 and rd_address/wr_data SHALL hold their last values.
REQ-017 Back-to-back transfers SHALL sustain one write per cycle.
REQ-018 issue_ready SHALL equal NOT busy[issue_rd] (WAW blocking); an accepted issue SHALL set busy[issue_rd] at the next edge.
REQ-019 A cycle with wr_enable = 1 SHALL clear busy[rd_address] at the following edge.
REQ-020 When an issue set and a write clear target the same register in one cycle, set SHALL win.
REQ-021 hazard SHALL equal busy[rs1_address] OR busy[rs2_address] OR busy[rs3_address], combinationally.
REQ-022 All 32 registers, including register 0, SHALL be tracked and writable.

Reset
REQ-023 On rst_n = 1 at an edge: busy = 0, wr_enable = 0, rd_address = 0, wr_data = 0, last-grant pointer = 1; requests presented during reset are not transferred.
REQ-024 An in-flight write registered in the cycle reset asserts SHALL be dropped (wr_enable = 0 after the edge).

Configuration
REQ-025 Macro P_WB_BYPASS_EN defined: hazard SHALL additionally mask any rsN_address equal to rd_address while wr_enable = 1, and a 3-bit output fwd_hit SHALL flag which rsN matches that write.
REQ-026 Macro P_WB_BYPASS_EN undefined: fwd_hit SHALL not exist, and hazard follows REQ-021 only.

Verification
REQ-027 Reset then idle: rst_n = 1 for 2 cycles with both valid = 1 -> both ready = 0, wr_enable = 0, busy = 0.
REQ-028 Both valid every cycle, req0_rd = 3 / data A5A5A5A5A5A5A5A5, req1_rd = 4 / data 5A5A5A5A5A5A5A5A -> grants alternate 0,1,0,1 and wr_enable stays 1 from cycle 2 on.
REQ-029 Issue rd = 5, then rs2_address = 5 -> hazard = 1; req1 writes rd 5 -> hazard = 0 one cycle after wr_enable = 1 (same cycle with P_WB_BYPASS_EN, fwd_hit = 010).
REQ-030 Issue rd = 7 while busy[7] = 1 -> issue_ready = 0, busy unchanged; same-cycle issue of 9 and write of 9 -> busy[9] = 1.
REQ-031 wb_stall = 1 for 3 cycles with req0_valid = 1 -> no ready and no wr_enable; stall release -> req0 granted next cycle.
REQ-032 rst_n = 1 in the cycle after a transfer -> wr_enable = 0 and busy = 0 after the edge.
